// File: rtl/add_cp_pipe.sv
// add_cp_pipe: carry-pipelined adder/subtractor resolving CHUNK bits per stage.
// Unresolved operand chunks skew forward; finished sum chunks deskew forward.
module add_cp_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int S = WIDTH / CHUNK;

  logic             stall;
  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             c0;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = rst_n & ~stall;
  assign bx       = sub ? ~b : b;
  assign c0       = sub | cin;

  for (genvar k = 0; k < S; k++) begin : g_stg
    localparam int LO = k * CHUNK;
    localparam int HW = WIDTH - LO - CHUNK;

    logic [CHUNK-1:0]    ach;
    logic [CHUNK-1:0]    bch;
    logic                cin_k;
    logic                vin_k;
    logic [CHUNK:0]      part;
    logic [LO+CHUNK-1:0] s_d;
    logic                v_q;
    logic                c_q;
    logic [LO+CHUNK-1:0] s_q;

    if (k == 0) begin : g_head
      assign ach   = a[CHUNK-1:0];
      assign bch   = bx[CHUNK-1:0];
      assign cin_k = c0;
      assign vin_k = in_valid & in_ready;
      assign s_d   = part[CHUNK-1:0];
    end else begin : g_body
      assign ach   = g_stg[k-1].g_skew.a_q[CHUNK-1:0];
      assign bch   = g_stg[k-1].g_skew.b_q[CHUNK-1:0];
      assign cin_k = g_stg[k-1].c_q;
      assign vin_k = g_stg[k-1].v_q;
      assign s_d   = {part[CHUNK-1:0], g_stg[k-1].s_q};
    end

    assign part = {1'b0, ach} + {1'b0, bch}
                + {{CHUNK{1'b0}}, cin_k};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= vin_k;
        c_q <= part[CHUNK];
        s_q <= s_d;
      end
    end

    if (k < S - 1) begin : g_skew
      logic [HW-1:0] a_q;
      logic [HW-1:0] b_q;
      logic [HW-1:0] a_d;
      logic [HW-1:0] b_d;

      if (k == 0) begin : g_src
        assign a_d = a[WIDTH-1:CHUNK];
        assign b_d = bx[WIDTH-1:CHUNK];
      end else begin : g_src
        assign a_d = g_stg[k-1].g_skew.a_q[HW+CHUNK-1:CHUNK];
        assign b_d = g_stg[k-1].g_skew.b_q[HW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      // carry into the MSB, recovered from the top bit's inputs and sum
      logic cm_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cm_q <= 1'b0;
        end else if (adv) begin
          cm_q <= ach[CHUNK-1] ^ bch[CHUNK-1] ^ part[CHUNK-1];
        end
      end
    end
  end

  assign out_valid = g_stg[S-1].v_q;
  assign sum       = g_stg[S-1].s_q;
  assign cout      = g_stg[S-1].c_q;
  assign ovf       = g_stg[S-1].g_last.cm_q ^ g_stg[S-1].c_q;

endmodule

// File: tb/tb_add_cp_pipe.sv
// tb_add_cp_pipe: directed vectors, queue scoreboard, decoupled monitor.
// WIDTH=16, CHUNK=4, so four pipeline stages.
module tb_add_cp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int base = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   out_cyc[$];
  exp_t me;

  logic [15:0] stream_exp [8] = '{16'h0000, 16'h1001, 16'h2002,
    16'h3003, 16'h4004, 16'h5005, 16'h6006, 16'h7007};

  add_cp_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {16'h0, sum}, 32'hFFFF_FFFF);
      end else begin
        me = sb.pop_front();
        chk("sum", {16'h0, sum}, {16'h0, me.s});
        chk("cout", {31'h0, cout}, {31'h0, me.c});
        chk("ovf", {31'h0, ovf}, {31'h0, me.o});
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [15:0] ta, input logic [15:0] tbv,
                      input logic tc, input logic ts,
                      input logic [15:0] es, input logic ec,
                      input logic eo);
    int   n = 0;
    logic acc = 1'b0;
    exp_t e;
    a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", {31'h0, acc}, 32'd1);
    if (acc) begin
      e.s = es; e.c = ec; e.o = eo;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_sum", {16'h0, sum}, 32'd0);
    chk("rst_cout", {31'h0, cout}, 32'd0);
    chk("rst_ovf", {31'h0, ovf}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // latency of exactly four cycles, carry across a chunk boundary
    send(16'h00F8, 16'h0013, 1'b0, 1'b0, 16'h010B, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("lat_early", {31'h0, out_valid}, 32'd0);
    end
    @(negedge clk);
    chk("lat_four", {31'h0, out_valid}, 32'd1);
    @(posedge clk); #1;
    drain();

    // directed arithmetic vectors, back to back
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    idle(1);
    drain();

    // out_ready low with no valid output must not stall bubbles
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("bubble_adv", {31'h0, out_valid}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // streaming, one result per cycle in order
    out_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      send(16'(i), 16'(i * 16'h1000), 1'b0, 1'b0,
           stream_exp[i], 1'b0, 1'b0);
      if (i == 0) base = cyc;
    end
    in_valid = 1'b0;
    drain();
    chk("stream_cnt", out_cyc.size(), 32'd8);
    if (out_cyc.size() == 8) begin
      chk("stream_first", out_cyc[0], base + 3);
      for (int j = 1; j < 8; j++)
        chk("stream_gap", out_cyc[j] - out_cyc[j-1], 32'd1);
    end

    // same stream with a three cycle stall after the first result
    out_cyc.delete();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'(i), 16'(i * 16'h1000), 1'b0, 1'b0,
               stream_exp[i], 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("stall_seen", {31'h0, out_valid}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("stall_in_ready", {31'h0, in_ready}, 32'd0);
          chk("stall_valid", {31'h0, out_valid}, 32'd1);
          chk("stall_hold", {16'h0, sum}, 32'h1001);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cnt", out_cyc.size(), 32'd8);

    // reset mid-flight discards everything, inputs held during reset
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    send(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0);
    send(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0);
    a = 16'hAAAA;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'd0);
    @(posedge clk); #1;
    sb.delete();
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0)
        chk("midrst_rel_ready", {31'h0, in_ready}, 32'd1);
      chk("midrst_no_out", {31'h0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/add_cp_pipe.md
ADD_CP_PIPE -- requirements
Module: add_cp_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/sum width in bits; SHALL be an integer multiple of CHUNK and >= CHUNK.
REQ-002 Parameter CHUNK, default 4, bits resolved per pipeline stage; number of stages S = WIDTH/CHUNK.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port in_valid  input  1  operand beat present.
REQ-006 Port in_ready  output  1  block accepts beat this cycle.
REQ-007 Port a  input  WIDTH  operand A (unsigned or two's complement).
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port cin  input  1  carry-in; ignored when sub=1.
REQ-010 Port sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  downstream accepts result.
REQ-013 Port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 Port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 Port ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Function
REQ-016 Beat accepted on cycle where in_valid=1 and in_ready=1; a, b, cin, sub SHALL be sampled together on that edge.
REQ-017 Stage k (0..S-1) SHALL add chunk k of A and B' (B'=~B when sub=1, else B) with carry from stage k-1; stage 0 carry = sub ? 1 : cin.
REQ-018 Higher chunks not yet resolved SHALL be carried forward registered (skew buffers); resolved lower sum chunks SHALL be carried forward registered (deskew buffers).
REQ-019 Latency: result of an accepted beat SHALL appear on out_valid exactly S cycles after acceptance when never stalled.
REQ-020 Throughput: one beat per cycle while out_ready=1; results SHALL emerge in acceptance order, none dropped or duplicated.
REQ-021 Stall: when out_valid=1 and out_ready=0, entire pipeline SHALL hold; in_ready SHALL be 0 in that cycle (in_ready = !(out_valid & !out_ready)).
REQ-022 Bubbles: stages with no valid beat SHALL advance regardless of out_ready only when not stalled; out_valid=0 with out_ready=0 SHALL NOT stall.
REQ-023 sum, cout, ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous accept and stall release: beat accepted same cycle the output is consumed SHALL be retained, no loss.
REQ-025 S=1 (CHUNK=WIDTH) SHALL degenerate to single registered stage, latency 1.
REQ-026 Wrap-around: sum SHALL be truncated to WIDTH bits; no saturation.

Reset
REQ-027 While rst_n=0 at a clock edge, all stage valid flags SHALL clear; out_valid=0, sum=0, cout=0, ovf=0 after that edge.
REQ-028 in_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after rst_n returns high.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear after reset release.
REQ-030 Inputs presented during reset SHALL NOT be accepted.

Verification (WIDTH=16, CHUNK=4, S=4)
REQ-031 Accept a=0x00F8, b=0x0013, cin=0, sub=0; out_ready=1 -> 4 cycles later out_valid=1, sum=0x010B, cout=0, ovf=0 (carry crosses chunk boundary).
REQ-032 a=0xFFFF, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1, ovf=0 (full carry ripple through all stages).
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1; then a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-034 Stream 8 back-to-back beats (a=i, b=0x1000*i) with out_ready=1 -> 8 results on consecutive cycles starting cycle 4, in order, correct values.
REQ-035 Same stream with out_ready=0 for 3 cycles after first out_valid -> in_ready=0 during stall, sum held constant, all 8 results delivered in order, none lost.
REQ-036 Accept 3 beats, assert rst_n=0 for one edge, release -> out_valid stays 0 for 6 following cycles; in_ready=1 first cycle after release.
